dmem_ctrl: RTL and testbench

- Parametrised data-memory controller that replaces the core's single-cycle data memory.
- Provides a valid/ready request channel from the core and a one-cycle response pulse.
- Read latency is configurable; sub-word accesses use byte-lane steering with sign/zero extension.
- Misaligned and out-of-range accesses are detected and reported.
- Sits between the core's load/store unit and a word-organised RAM array held inside the block.

---
 rtl/dmem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready requests, configurable read latency, byte-lane steering
// and error reporting. Optional performance counters are built when DMEM_PERF_CNT_EN is defined.
module dmem_ctrl #(
  parameter int unsigned MP_DATA_WIDTH = 32,
  parameter int unsigned MP_ADDR_WIDTH = 8,
  parameter int unsigned MP_RD_LATENCY = 1
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ireq_valid,
  output logic                     oreq_ready,
  input  logic [31:0]              iaddr,
  input  logic                     iwen,
  input  logic [1:0]               isize,
  input  logic                     isigned,
  input  logic [MP_DATA_WIDTH-1:0] iwdata,
  output logic                     oresp_valid,
  output logic                     oresp_err,
  output logic [MP_DATA_WIDTH-1:0] ordata
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]              ocnt_rd,
  output logic [31:0]              ocnt_wr,
  output logic [31:0]              ocnt_err
`endif
);

  localparam int unsigned NumBytes = MP_DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(NumBytes);
  localparam int unsigned IdxTop   = LaneBits + MP_ADDR_WIDTH;
  localparam int unsigned Depth    = 2 ** MP_ADDR_WIDTH;
  localparam logic [31:0] InRange  = 32'((64'd1 << IdxTop) - 64'd1);
  localparam logic [2:0]  RdLatM1  = 3'(MP_RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               lat_cnt_q, lat_cnt_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic [MP_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [MP_DATA_WIDTH-1:0] ld_q, ld_d;

  logic [MP_DATA_WIDTH-1:0] mem_q [Depth];

  logic                     accept;
  logic                     acc_err, misalign, size_err, range_err;
  logic [LaneBits-1:0]      off;
  logic [MP_ADDR_WIDTH-1:0] widx;
  logic [NumBytes-1:0]      be;
  logic [MP_DATA_WIDTH-1:0] wdata_sh, rd_shift, ld_ext;
  logic                     sign_bit;
  int                       nb, nbits;

  assign off    = iaddr[LaneBits-1:0];
  assign widx   = iaddr[IdxTop-1:LaneBits];
  assign accept = ireq_valid & ready_q;

  always_comb begin
    case (isize)
      2'b01:   misalign = iaddr[0];
      2'b10:   misalign = |iaddr[1:0];
      2'b11:   misalign = |iaddr[2:0];
      default: misalign = 1'b0;
    endcase
    size_err  = (isize == 2'b11) && (MP_DATA_WIDTH == 32);
    range_err = |(iaddr & ~InRange);
    acc_err   = misalign | size_err | range_err;
  end

  // Store steering: lanes [off, off+nb) enabled, data moved up to the addressed lane.
  always_comb begin
    nb = 1 << isize;
    for (int i = 0; i < int'(NumBytes); i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + nb);
    end
    wdata_sh = iwdata << {off, 3'b000};
  end

  always_comb begin
    rd_shift = mem_q[widx] >> {off, 3'b000};
    nbits    = 8 << isize;
    case (isize)
      2'b00:   sign_bit = rd_shift[7];
      2'b01:   sign_bit = rd_shift[15];
      2'b10:   sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[MP_DATA_WIDTH-1];
    endcase
    for (int i = 0; i < int'(MP_DATA_WIDTH); i++) begin
      ld_ext[i] = (i < nbits) ? rd_shift[i] : (isigned & sign_bit);
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    ld_d      = ld_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d = acc_err;
          ld_d  = '0;
          if (acc_err || iwen) begin
            state_d = StResp;
          end else begin
            // Load result is captured now; later cycles only delay its delivery.
            ld_d = ld_ext;
            if (MP_RD_LATENCY == 1) begin
              state_d = StResp;
            end else begin
              state_d   = StRdWait;
              lat_cnt_d = RdLatM1;
            end
          end
        end
      end
      StRdWait: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StResp);
    rdata_d = valid_d ? ld_d : '0;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= StIdle;
      lat_cnt_q <= 3'd0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ld_q      <= ld_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge iclk) begin
    if (accept && iwen && !acc_err) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign oreq_ready  = ready_q;
  assign oresp_valid = valid_q;
  assign oresp_err   = err_q;
  assign ordata      = rdata_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d, cnt_err_q, cnt_err_d;

  always_comb begin
    cnt_rd_d  = cnt_rd_q;
    cnt_wr_d  = cnt_wr_q;
    cnt_err_d = cnt_err_q;
    if (accept && !acc_err && !iwen && (cnt_rd_q != '1)) cnt_rd_d = cnt_rd_q + 32'd1;
    if (accept && !acc_err && iwen && (cnt_wr_q != '1))  cnt_wr_d = cnt_wr_q + 32'd1;
    if (valid_q && err_q && (cnt_err_q != '1))           cnt_err_d = cnt_err_q + 32'd1;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign ocnt_rd  = cnt_rd_q;
  assign ocnt_wr  = cnt_wr_q;
  assign ocnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (read latency 1 and 3) checked every cycle against a
// byte-addressed memory model with an absolute-cycle response schedule.
module tb_dmem_ctrl;

  localparam int LatA = 1;
  localparam int LatB = 3;

  logic        clk, rst_n;
  logic        req_valid [2];
  logic [31:0] addr      [2];
  logic        wen       [2];
  logic [1:0]  size      [2];
  logic        sgn       [2];
  logic [31:0] wdata     [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic        resp_err  [2];
  logic [31:0] rdata     [2];
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] cnt_rd[2], cnt_wr[2], cnt_er[2];
`endif

  dmem_ctrl #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(8), .MP_RD_LATENCY(LatA)) u_dut_a (
    .iclk(clk), .irst_n(rst_n), .ireq_valid(req_valid[0]), .oreq_ready(req_ready[0]),
    .iaddr(addr[0]), .iwen(wen[0]), .isize(size[0]), .isigned(sgn[0]), .iwdata(wdata[0]),
    .oresp_valid(resp_valid[0]), .oresp_err(resp_err[0]), .ordata(rdata[0])
`ifdef DMEM_PERF_CNT_EN
    , .ocnt_rd(cnt_rd[0]), .ocnt_wr(cnt_wr[0]), .ocnt_err(cnt_er[0])
`endif
  );

  dmem_ctrl #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(8), .MP_RD_LATENCY(LatB)) u_dut_b (
    .iclk(clk), .irst_n(rst_n), .ireq_valid(req_valid[1]), .oreq_ready(req_ready[1]),
    .iaddr(addr[1]), .iwen(wen[1]), .isize(size[1]), .isigned(sgn[1]), .iwdata(wdata[1]),
    .oresp_valid(resp_valid[1]), .oresp_err(resp_err[1]), .ordata(rdata[1])
`ifdef DMEM_PERF_CNT_EN
    , .ocnt_rd(cnt_rd[1]), .ocnt_wr(cnt_wr[1]), .ocnt_err(cnt_er[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: byte memory, absolute cycle numbers for readiness and the pending response.
  logic [7:0]  mbyte [2][1024];
  int          cyc;
  int          ready_from[2], resp_at[2], acc_cnt[2], acc_cyc[2], resp_cyc[2], resp_seen[2];
  logic        exp_err[2];
  logic [31:0] exp_data[2], last_data[2];
  logic        last_err[2];
  int          n_ld[2], n_st[2], n_er[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input int d);
    int unsigned ua;
    int          nb, lat;
    logic        e;
    logic [31:0] v;
    ua  = addr[d];
    nb  = 1 << size[d];
    e   = (size[d] == 2'b11) || ((ua % nb) != 0) || (ua >= 1024);
    v   = '0;
    lat = 1;
    if (e) begin
      n_er[d]++;
    end else if (wen[d]) begin
      for (int i = 0; i < nb; i++) mbyte[d][int'(ua) + i] = wdata[d][8*i +: 8];
      n_st[d]++;
    end else begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mbyte[d][int'(ua) + i];
      if (sgn[d] && nb < 4 && v >= (32'd1 << (8*nb - 1))) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      lat = (d == 0) ? LatA : LatB;
      n_ld[d]++;
    end
    resp_at[d]    = cyc + lat;
    ready_from[d] = cyc + lat + 1;
    exp_err[d]    = e;
    exp_data[d]   = v;
    acc_cyc[d]    = cyc;
    acc_cnt[d]++;
  endtask

  // Compare process: once per cycle at the falling edge.
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) mbyte[d][i] = 8'h00;
      ready_from[d] = 0; resp_at[d] = -1; acc_cnt[d] = 0; acc_cyc[d] = 0; resp_cyc[d] = 0;
      resp_seen[d] = 0; n_ld[d] = 0; n_st[d] = 0; n_er[d] = 0;
      last_data[d] = '0; last_err[d] = 1'b0; exp_err[d] = 1'b0; exp_data[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd0);
          chk($sformatf("rst_valid%0d", d), 32'(resp_valid[d]), 32'd0);
          chk($sformatf("rst_err%0d", d), 32'(resp_err[d]), 32'd0);
          chk($sformatf("rst_data%0d", d), rdata[d], 32'd0);
          ready_from[d] = cyc + 2;
          resp_at[d]    = -1;
          n_ld[d] = 0; n_st[d] = 0; n_er[d] = 0;
        end else begin
          chk($sformatf("ready%0d@%0d", d, cyc), 32'(req_ready[d]), 32'(cyc >= ready_from[d]));
          chk($sformatf("valid%0d@%0d", d, cyc), 32'(resp_valid[d]), 32'(cyc == resp_at[d]));
          if (cyc == resp_at[d]) begin
            chk($sformatf("err%0d@%0d", d, cyc), 32'(resp_err[d]), 32'(exp_err[d]));
            chk($sformatf("data%0d@%0d", d, cyc), rdata[d], exp_data[d]);
          end
          if (resp_valid[d] === 1'b1) begin
            resp_seen[d]++;
            resp_cyc[d]  = cyc;
            last_data[d] = rdata[d];
            last_err[d]  = resp_err[d];
          end
          if (req_valid[d] && cyc >= ready_from[d]) model_accept(d);
        end
      end
      cyc++;
    end
  end

  task automatic set_req(input int d, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    wen[d] = w; size[d] = sz; sgn[d] = sg; addr[d] = a; wdata[d] = wd; req_valid[d] = 1'b1;
  endtask

  // Leaves valid asserted so that back-to-back requests can follow immediately.
  task automatic req(input int d, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    int n0, k;
    n0 = acc_cnt[d];
    k  = 0;
    set_req(d, w, sz, sg, a, wd);
    do begin
      @(posedge clk); #1;
      k++;
    end while (acc_cnt[d] == n0 && k < 40);
    if (acc_cnt[d] == n0) chk($sformatf("accept_timeout%0d", d), 32'd0, 32'd1);
  endtask

  task automatic op(input int d, input logic w, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input logic xe,
                    input logic [31:0] xd, input string name);
    int r0;
    r0 = resp_seen[d];
    req(d, w, sz, sg, a, wd);
    req_valid[d] = 1'b0;
    repeat (((d == 0) ? LatA : LatB) + 1) @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(resp_seen[d] - r0), 32'd1);
    chk({name, "_err"}, 32'(last_err[d]), 32'(xe));
    chk({name, "_data"}, last_data[d], xd);
  endtask

  int c0, r0;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) set_req(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_before_first_edge", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_first_edge", 32'(req_ready[0]), 32'd1);
    repeat (2) @(posedge clk); #1;

    // Reset asserted right after a load is accepted: no response may appear.
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("ready_in_reset", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "st_w10");
    op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "ld_w10");
    chk("ld_w10_latency", 32'(resp_cyc[0] - acc_cyc[0]), 32'd1);

    op(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0, 32'h0, "st_w20");
    op(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80, "ld_bs23");
    op(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, 32'h00000080, "ld_bu23");
    op(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00007F01, "ld_hs20");
    op(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF, "ld_hs22");
    op(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'h000080FF, "ld_hu22");

    op(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 1'b0, 32'h0, "st_w30");
    op(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h123456AA, 1'b0, 32'h0, "st_b31");
    op(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h1122AA44, "ld_w30a");
    op(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h7777BEEF, 1'b0, 32'h0, "st_h32");
    op(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'hBEEFAA44, "ld_w30b");

    op(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0, "err_ld_h21");
    op(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 1'b1, 32'h0, "err_st_w22");
    op(0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, "err_ld_w400");
    op(0, 1'b1, 2'b11, 1'b0, 32'h28, 32'h55555555, 1'b1, 32'h0, "err_st_d28");
    op(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80FF7F01, "ld_w20_after_err");

    // Latency 3 instance: back-to-back loads with valid held high.
    op(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, "b_st_w40");
    op(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h00001234, 1'b0, 32'h0, "b_st_w44");
    r0 = resp_seen[1];
    req(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    c0 = acc_cyc[1];
    req(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    chk("b2b_gap1", 32'(acc_cyc[1] - c0), 32'd4);
    c0 = acc_cyc[1];
    req(1, 1'b0, 2'b01, 1'b1, 32'h46, 32'h0);
    chk("b2b_gap2", 32'(acc_cyc[1] - c0), 32'd4);
    c0 = acc_cyc[1];
    req(1, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    chk("b2b_gap3", 32'(acc_cyc[1] - c0), 32'd4);
    req_valid[1] = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("b2b_resp_count", 32'(resp_seen[1] - r0), 32'd4);
    chk("b2b_latency", 32'(resp_cyc[1] - acc_cyc[1]), 32'd3);
    chk("b2b_last_data", last_data[1], 32'hFFFFFFA5);
    op(1, 1'b0, 2'b10, 1'b1, 32'h3FD, 32'h0, 1'b1, 32'h0, "b_err_w3fd");

`ifdef DMEM_PERF_CNT_EN
    chk("cnt_rd", cnt_rd[0], 32'(n_ld[0]));
    chk("cnt_wr", cnt_wr[0], 32'(n_st[0]));
    chk("cnt_err", cnt_er[0], 32'(n_er[0]));
    chk("cnt_err_b", cnt_er[1], 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("cnt_rd_rst", cnt_rd[0], 32'd0);
    chk("cnt_wr_rst", cnt_wr[0], 32'd0);
    chk("cnt_err_rst", cnt_er[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
